// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the 7-segment scan controller.
// Digit count, idle anode pattern, digit index, brightness and scan FSM states.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] bright_t;

    typedef enum logic [1:0] {
        S_BLANK,
        S_ON,
        S_OFF
    } scan_state_t;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [NUM_DIGITS-1:0] anode_onehot(digit_idx_t i);
        return ANODE_OFF ^ (NUM_DIGITS'(1) << i);
    endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// scan_slot_timer: per-digit slot counter and timing strobes.
// Produces slot-end, pre-end, blank-end and PWM on-end strobes.
module scan_slot_timer
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 25000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    run,
    input  bright_t bright,
    output logic    slot_end,
    output logic    pre_end,
    output logic    blank_end,
    output logic    on_end,
    output logic    on_zero
);

    localparam int CW     = $clog2(REFRESH_DIV);
    localparam int PW     = CW + 5;
    localparam int ACTIVE = REFRESH_DIV - BLANK_CYCLES;

    logic [CW-1:0] slot_cnt;
    logic [PW-1:0] prod;
    logic [PW-1:0] on_len;
    logic [PW-1:0] cnt_w;

    // Slot counter: held at zero while stopped, wraps at slot end.
    always_ff @(posedge clk) begin
        if (reset || !run || slot_end) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + CW'(1);
        end
    end

    // Lit length scales the post-blank window by (bright+1)/16.
    assign prod   = PW'(ACTIVE) * PW'({1'b0, bright} + 5'd1);
    assign on_len = prod >> 4;
    assign cnt_w  = PW'(slot_cnt);

    assign slot_end  = (slot_cnt == CW'(REFRESH_DIV - 1));
    assign pre_end   = (slot_cnt == CW'(REFRESH_DIV - 2));
    assign blank_end = (slot_cnt == CW'(BLANK_CYCLES - 1));
    assign on_zero   = (on_len == '0);
    assign on_end    = (cnt_w == PW'(BLANK_CYCLES - 1) + on_len);

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit multiplexed 7-segment scan with blank guard and PWM.
// Optional blinking is enabled by defining DISPLAY_SCAN_BLINK_EN.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 25000,
    parameter int BLANK_CYCLES = 500
`ifdef DISPLAY_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 256
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load_Valid,
    output logic        load_Ready,
    input  logic [15:0] load_Digits,
    input  logic [3:0]  load_Mask,
    input  logic [3:0]  load_Dp,
    input  logic [3:0]  load_Bright,
`ifdef DISPLAY_SCAN_BLINK_EN
    input  logic [3:0]  load_Blink,
`endif
    output logic [3:0]  anode_Out,
    output logic [1:0]  anode_Sel,
    output logic [3:0]  digit_Out,
    output logic        dp_Out,
    output logic        frame_Done
);

    scan_state_t state, state_n;
    digit_idx_t  idx, idx_n;

    logic [15:0] act_digits, pnd_digits, act_digits_n;
    logic [3:0]  act_mask, pnd_mask, act_mask_n;
    logic [3:0]  act_dp, pnd_dp, act_dp_n;
    bright_t     act_bright, pnd_bright;
    logic        pending;
    logic        xfer;
    logic        commit;
    logic [3:0]  mask_eff_n;

    logic slot_end, pre_end, blank_end, on_end, on_zero;

    scan_slot_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (enable),
        .bright   (act_bright),
        .slot_end (slot_end),
        .pre_end  (pre_end),
        .blank_end(blank_end),
        .on_end   (on_end),
        .on_zero  (on_zero)
    );

    // Frame end commits pending data; while stopped it commits at once.
    assign xfer   = load_Valid && load_Ready;
    assign commit = pending && (!enable || (slot_end && idx == 2'd3));

    assign act_digits_n = commit ? pnd_digits : act_digits;
    assign act_mask_n   = commit ? pnd_mask   : act_mask;
    assign act_dp_n     = commit ? pnd_dp     : act_dp;

`ifdef DISPLAY_SCAN_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] blink_cnt;
    logic          blink_on;
    logic [3:0]    act_blink, pnd_blink, act_blink_n;
    logic          frame_end;

    assign frame_end   = enable && slot_end && (idx == 2'd3);
    assign act_blink_n = commit ? pnd_blink : act_blink;
    assign mask_eff_n  = act_mask_n & ~(act_blink_n & {4{~blink_on}});

    // Blink buffer and frame counter toggling the blink phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            act_blink <= '0;
            pnd_blink <= '0;
        end else begin
            if (xfer) begin
                pnd_blink <= load_Blink;
            end
            if (commit) begin
                act_blink <= pnd_blink;
            end
            if (frame_end) begin
                if (blink_cnt == FW'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + FW'(1);
                end
            end
        end
    end
`else
    assign mask_eff_n = act_mask_n;
`endif

    // Next scan state and digit index.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        if (!enable) begin
            state_n = S_BLANK;
            idx_n   = '0;
        end else if (slot_end) begin
            state_n = S_BLANK;
            idx_n   = idx + 2'd1;
        end else begin
            unique case (state)
                S_BLANK: begin
                    if (blank_end) begin
                        state_n = on_zero ? S_OFF : S_ON;
                    end
                end
                S_ON: begin
                    if (on_end) begin
                        state_n = S_OFF;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Scan state and digit index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_BLANK;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Shadow buffer: accept into pending, commit to active at frame end.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_digits <= '0;
            act_mask   <= '0;
            act_dp     <= '0;
            act_bright <= 4'hF;
            pnd_digits <= '0;
            pnd_mask   <= '0;
            pnd_dp     <= '0;
            pnd_bright <= 4'hF;
            pending    <= 1'b0;
            load_Ready <= 1'b1;
        end else begin
            if (commit) begin
                act_digits <= pnd_digits;
                act_mask   <= pnd_mask;
                act_dp     <= pnd_dp;
                act_bright <= pnd_bright;
                pending    <= 1'b0;
                load_Ready <= 1'b1;
            end
            if (xfer) begin
                pnd_digits <= load_Digits;
                pnd_mask   <= load_Mask;
                pnd_dp     <= load_Dp;
                pnd_bright <= load_Bright;
                pending    <= 1'b1;
                load_Ready <= 1'b0;
            end
        end
    end

    // Output registers follow the next state; index only moves at slot start.
    always_ff @(posedge clk) begin
        if (reset) begin
            anode_Out  <= ANODE_OFF;
            anode_Sel  <= '0;
            digit_Out  <= '0;
            dp_Out     <= 1'b1;
            frame_Done <= 1'b0;
        end else begin
            if (state_n == S_ON && mask_eff_n[idx_n]) begin
                anode_Out <= anode_onehot(idx_n);
            end else begin
                anode_Out <= ANODE_OFF;
            end
            anode_Sel  <= idx_n;
            digit_Out  <= act_digits_n[{idx_n, 2'b00} +: 4];
            dp_Out     <= !(state_n == S_ON && act_dp_n[idx_n]
                            && mask_eff_n[idx_n]);
            frame_Done <= enable && pre_end && (idx == 2'd3);
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: randomized bench for display_scan_ctrl.
// Compares every cycle against a frame-position reference model.
module tb_display_scan_ctrl;

    localparam int R  = 16;
    localparam int B  = 2;
    localparam int FR = 4 * R;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load_Valid;
    logic        load_Ready;
    logic [15:0] load_Digits;
    logic [3:0]  load_Mask;
    logic [3:0]  load_Dp;
    logic [3:0]  load_Bright;
    logic [3:0]  anode_Out;
    logic [1:0]  anode_Sel;
    logic [3:0]  digit_Out;
    logic        dp_Out;
    logic        frame_Done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame position plus active/pending frame contents.
    int          p;
    logic [15:0] m_dig, q_dig;
    logic [3:0]  m_mask, q_mask, m_dp, q_dp, m_br, q_br;
    logic        pend;

    display_scan_ctrl #(
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load_Valid (load_Valid),
        .load_Ready (load_Ready),
        .load_Digits(load_Digits),
        .load_Mask  (load_Mask),
        .load_Dp    (load_Dp),
        .load_Bright(load_Bright),
        .anode_Out  (anode_Out),
        .anode_Sel  (anode_Sel),
        .digit_Out  (digit_Out),
        .dp_Out     (dp_Out),
        .frame_Done (frame_Done)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step();
        int         slot, off, onl;
        logic       xf, lit;
        logic [3:0] an;
        @(posedge clk);
        if (reset) begin
            p = 0;
            m_dig = '0; m_mask = '0; m_dp = '0; m_br = 4'hF;
            pend = 1'b0;
        end else begin
            xf = load_Valid && !pend;
            if (pend && (!enable || p == FR - 1)) begin
                m_dig = q_dig; m_mask = q_mask; m_dp = q_dp; m_br = q_br;
                pend = 1'b0;
            end
            if (xf) begin
                q_dig = load_Digits; q_mask = load_Mask;
                q_dp = load_Dp; q_br = load_Bright;
                pend = 1'b1;
            end
            p = enable ? (p + 1) % FR : 0;
        end
        #1;
        slot = p / R;
        off  = p % R;
        onl  = ((R - B) * (int'(m_br) + 1)) / 16;
        lit  = (off >= B) && (off - B < onl) && m_mask[slot];
        an   = lit ? (4'hF ^ (4'h1 << slot)) : 4'hF;
        check("anode", 32'(anode_Out), 32'(an));
        check("sel", 32'(anode_Sel), 32'(slot));
        check("digit", 32'(digit_Out), 32'(m_dig[slot*4 +: 4]));
        check("dp", 32'(dp_Out), 32'(!(lit && m_dp[slot])));
        check("frame_done", 32'(frame_Done), 32'(p == FR - 1));
        check("ready", 32'(load_Ready), 32'(!pend));
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_frame(logic [15:0] d, logic [3:0] m,
                              logic [3:0] dp, logic [3:0] br);
        for (int i = 0; i < 4 * FR && pend; i++) step();
        load_Valid = 1'b1;
        load_Digits = d; load_Mask = m; load_Dp = dp; load_Bright = br;
        step();
        load_Valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load_Valid = 1'b0;
        load_Digits = '0; load_Mask = '0; load_Dp = '0; load_Bright = '0;
        p = 0; pend = 1'b0;
        m_dig = '0; m_mask = '0; m_dp = '0; m_br = 4'hF;
        q_dig = '0; q_mask = '0; q_dp = '0; q_br = 4'hF;
        run(2);
        reset = 1'b0; enable = 1'b1;

        load_frame(16'h1234, 4'hF, 4'h0, 4'hF);
        run(2 * FR + 10);
        load_frame(16'h1234, 4'hF, 4'h0, 4'h7);
        run(2 * FR);
        load_frame(16'h1234, 4'hF, 4'h0, 4'h0);
        run(2 * FR);
        load_frame(16'h5678, 4'b0101, 4'b0001, 4'hF);
        run(2 * FR);

        // Mid-frame load followed by an ignored second offer.
        run(20);
        load_Valid = 1'b1;
        load_Digits = 16'hABCD; load_Mask = 4'hF;
        load_Dp = 4'hF; load_Bright = 4'hF;
        step();
        load_Digits = 16'h9999; load_Mask = 4'h3; load_Bright = 4'h1;
        step();
        load_Valid = 1'b0;
        run(2 * FR);

        // Drop enable while digit 2 is lit, then resume.
        for (int i = 0; i < FR && !(p / R == 2 && p % R == 5); i++) step();
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(FR + 8);

        // Reset while data is pending.
        run(10);
        load_frame(16'hFEDC, 4'hF, 4'hF, 4'hF);
        run(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(FR);

        // Randomized traffic with enable drops and rare resets.
        for (int i = 0; i < 3000; i++) begin
            load_Valid  = ($urandom_range(0, 7) == 0);
            load_Digits = 16'($urandom);
            load_Mask   = 4'($urandom);
            load_Dp     = 4'($urandom);
            case ($urandom_range(0, 3))
                0: load_Bright = 4'h0;
                1: load_Bright = 4'hF;
                default: load_Bright = 4'($urandom);
            endcase
            if (enable && $urandom_range(0, 99) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            reset = ($urandom_range(0, 599) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
